uart_cmd_receiver: RTL and testbench
====================================

Name: uart_cmd_receiver

Overview:
Host-to-analyzer command path. It unloads bytes from the UART receiver and parses framed commands. It drives the capture configuration registers (trigger mask, sample divider) and the one-cycle control pulses (arm, capture reset). It is the receive-side counterpart of the FIFO-to-UART readout path on the same serial link.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 500000, max clk cycles between bytes of one frame (10 ms at 50 MHz); must be >= 2
MASK_RESET, 3'b111, trig_mask value after reset
DIV_RESET, 16'd1, sample_div value after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_empty  in  1  UART RX buffer empty flag (low = byte waiting)
rx_data  in  8  UART RX data, valid the cycle after uld_rx_data
uld_rx_data  out  1  one-cycle unload strobe to UART RX
trig_mask  out  3  trigger input mask
sample_div  out  16  sample clock divider
arm_pulse  out  1  one-cycle arm strobe to trigger block
capture_rst  out  1  one-cycle capture/FIFO reset strobe
cmd_ok  out  1  one-cycle: frame accepted and applied
cmd_err  out  1  one-cycle: frame rejected
err_count  out  8  rejected-frame count, saturating at 255
state_debug  out  3  current FSM state encoding

Behaviour:
- Reset is clk and rst, synchronous, active-high. It overrides everything, including a partial frame. Reset values: uld_rx_data=0, arm_pulse=0, capture_rst=0, cmd_ok=0, cmd_err=0, err_count=0, trig_mask=MASK_RESET, sample_div=DIV_RESET, state=WAIT_BYTE, field=SYNC.
- Frame format: SYNC_BYTE, OPC, payload (0-2 bytes, length set by OPC), CHK. Valid when OPC ^ payload bytes ^ CHK == 8'h00.
- Opcodes:
  - 0x01 SET_MASK: 1 payload byte; trig_mask <= payload[2:0]; payload[7:3] ignored.
  - 0x02 SET_DIV: 2 payload bytes, MSB first; sample_div <= {p0,p1}. A value of 0 is rejected.
  - 0x03 ARM: 0 payload bytes.
  - 0x04 CAPTURE_RST: 0 payload bytes.
- Byte FSM:
  - WAIT_BYTE: if rx_empty==0, go to UNLOAD.
  - UNLOAD: uld_rx_data=1 for exactly this cycle; go to CAPTURE.
  - CAPTURE: latch rx_data; process the byte according to the field pointer; go to WAIT_BYTE.
- Rule: uld_rx_data is never asserted on two consecutive cycles, and at most once per 3 cycles.
- Field pointer (advanced only in CAPTURE):
  - SYNC: byte==SYNC_BYTE -> OPC, clear running XOR; any other byte is discarded silently (no cmd_err).
  - OPC: known opcode -> XOR <= byte, then PAY0, or CHK if length is 0. Unknown opcode -> cmd_err, back to SYNC.
  - PAY0 / PAY1: store the byte, XOR in, advance.
  - CHK: XOR with the byte. Zero result (and, for SET_DIV, a nonzero divider) -> cmd_ok. Otherwise -> cmd_err. Both outcomes return to SYNC.
- Accept timing: with uld on the CHK byte in cycle U, the byte is captured in U+1. The register update, arm_pulse/capture_rst, and cmd_ok are all visible in U+2 for exactly one cycle, and they appear together.
- Rejected frame: no register changes and no control pulses.
- Timeout: a gap counter clears on every CAPTURE and increments in WAIT_BYTE while field!=SYNC. When it reaches TIMEOUT_CYCLES-1 with rx_empty==1, the receiver pulses cmd_err and returns to SYNC. If rx_empty==0 in that same cycle, the byte takes priority and no timeout is declared. The counter is idle while field==SYNC.
- Error counting: err_count increments on each cmd_err and holds at 8'hFF.
- Back-to-back frames: SYNC_BYTE directly after CHK starts a new frame with no extra idle cycle.
- SYNC_BYTE inside a frame is treated as ordinary data; there is no resync.
- state_debug: {WAIT_BYTE=0, UNLOAD=1, CAPTURE=2}.

Test Plan:
- After reset, send A5 01 05 04 -> trig_mask=3'b101, one cmd_ok pulse, err_count=0, uld_rx_data pulsed 4 times.
- Send A5 02 12 34 24 -> sample_div=16'h1234, cmd_ok. Then send A5 02 00 00 02 -> cmd_err, sample_div stays 1234, err_count=1.
- Send A5 03 03 -> arm_pulse high exactly 1 cycle, coincident with cmd_ok. Send A5 04 04 -> capture_rst 1 cycle.
- Send FF 00 A5 01 07 06 -> leading junk discarded without cmd_err; trig_mask=3'b111. Send A5 01 07 00 (bad CHK) -> cmd_err, mask unchanged. Send A5 7E -> cmd_err (unknown opcode).
- TIMEOUT_CYCLES=20: send A5 01, then idle -> cmd_err 20 cycles after the last CAPTURE, state SYNC. A following full SET_MASK frame is accepted.
- Assert rst between PAY0 and CHK of a SET_DIV frame -> all outputs return to reset values and the trailing CHK byte is discarded as junk. Force 300 bad frames -> err_count=255.

Source files
------------

// File: rtl/uart_cmd_receiver.sv
// Command receiver for the host-to-analyzer serial link.
// Unloads bytes from the UART RX buffer and parses frames of the form
// SYNC_BYTE, OPC, payload (0-2 bytes), CHK, where OPC ^ payload ^ CHK == 0.
// Accepted frames update the capture configuration or fire a control strobe.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx_empty     UART RX empty flag (low = byte waiting)
//   rx_data      UART RX byte, valid the cycle after uld_rx_data
//   uld_rx_data  one-cycle unload strobe to the UART RX
//   trig_mask    trigger input mask
//   sample_div   sample clock divider
//   arm_pulse    one-cycle arm strobe
//   capture_rst  one-cycle capture/FIFO reset strobe
//   cmd_ok       one-cycle: frame accepted and applied
//   cmd_err      one-cycle: frame rejected (bad opcode, checksum, zero divider, timeout)
//   err_count    rejected-frame count, saturating at 255
//   state_debug  byte FSM state {WAIT_BYTE=0, UNLOAD=1, CAPTURE=2}
module uart_cmd_receiver #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [2:0]  MASK_RESET     = 3'b111,
  parameter logic [15:0] DIV_RESET      = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        uld_rx_data,
  output logic [2:0]  trig_mask,
  output logic [15:0] sample_div,
  output logic        arm_pulse,
  output logic        capture_rst,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic [7:0]  err_count,
  output logic [2:0]  state_debug
);

  localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OpSetMask = 8'h01;
  localparam logic [7:0] OpSetDiv  = 8'h02;
  localparam logic [7:0] OpArm     = 8'h03;
  localparam logic [7:0] OpCapRst  = 8'h04;

  typedef enum logic [1:0] {
    StWaitByte = 2'd0,
    StUnload   = 2'd1,
    StCapture  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    FldSync,
    FldOpc,
    FldPay0,
    FldPay1,
    FldChk
  } field_e;

  state_e          state_q, state_d;
  field_e          field_q, field_d;
  logic [7:0]      opc_q, opc_d;
  logic [7:0]      pay0_q, pay0_d;
  logic [7:0]      pay1_q, pay1_d;
  logic [7:0]      xor_q, xor_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [2:0]      trig_mask_q, trig_mask_d;
  logic [15:0]     sample_div_q, sample_div_d;
  logic            arm_q, arm_d;
  logic            caprst_q, caprst_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            frame_good;

  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    opc_d        = opc_q;
    pay0_d       = pay0_q;
    pay1_d       = pay1_q;
    xor_d        = xor_q;
    gap_d        = gap_q;
    trig_mask_d  = trig_mask_q;
    sample_div_d = sample_div_q;
    arm_d        = 1'b0;
    caprst_d     = 1'b0;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    frame_good   = 1'b0;

    unique case (state_q)
      StWaitByte: begin
        // A waiting byte always wins over a timeout in the same cycle.
        if (!rx_empty) begin
          state_d = StUnload;
        end else if (field_q != FldSync) begin
          if (gap_q == GapLast) begin
            err_d   = 1'b1;
            field_d = FldSync;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      StUnload: begin
        state_d = StCapture;
      end
      StCapture: begin
        state_d = StWaitByte;
        gap_d   = '0;
        unique case (field_q)
          FldSync: begin
            if (rx_data == SYNC_BYTE) begin
              field_d = FldOpc;
              xor_d   = 8'h00;
            end
          end
          FldOpc: begin
            opc_d = rx_data;
            xor_d = rx_data;
            if (rx_data == OpSetMask || rx_data == OpSetDiv) begin
              field_d = FldPay0;
            end else if (rx_data == OpArm || rx_data == OpCapRst) begin
              field_d = FldChk;
            end else begin
              err_d   = 1'b1;
              field_d = FldSync;
            end
          end
          FldPay0: begin
            pay0_d  = rx_data;
            xor_d   = xor_q ^ rx_data;
            field_d = (opc_q == OpSetDiv) ? FldPay1 : FldChk;
          end
          FldPay1: begin
            pay1_d  = rx_data;
            xor_d   = xor_q ^ rx_data;
            field_d = FldChk;
          end
          FldChk: begin
            field_d    = FldSync;
            frame_good = ((xor_q ^ rx_data) == 8'h00) &&
                         !((opc_q == OpSetDiv) && ({pay0_q, pay1_q} == 16'h0000));
            if (frame_good) begin
              ok_d = 1'b1;
              unique case (opc_q)
                OpSetMask: trig_mask_d  = pay0_q[2:0];
                OpSetDiv:  sample_div_d = {pay0_q, pay1_q};
                OpArm:     arm_d        = 1'b1;
                OpCapRst:  caprst_d     = 1'b1;
                default:   ;
              endcase
            end else begin
              err_d = 1'b1;
            end
          end
          default: field_d = FldSync;
        endcase
      end
      default: state_d = StWaitByte;
    endcase

    err_count_d = (err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWaitByte;
      field_q      <= FldSync;
      opc_q        <= 8'h00;
      pay0_q       <= 8'h00;
      pay1_q       <= 8'h00;
      xor_q        <= 8'h00;
      gap_q        <= '0;
      trig_mask_q  <= MASK_RESET;
      sample_div_q <= DIV_RESET;
      arm_q        <= 1'b0;
      caprst_q     <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      opc_q        <= opc_d;
      pay0_q       <= pay0_d;
      pay1_q       <= pay1_d;
      xor_q        <= xor_d;
      gap_q        <= gap_d;
      trig_mask_q  <= trig_mask_d;
      sample_div_q <= sample_div_d;
      arm_q        <= arm_d;
      caprst_q     <= caprst_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign uld_rx_data = (state_q == StUnload);
  assign trig_mask   = trig_mask_q;
  assign sample_div  = sample_div_q;
  assign arm_pulse   = arm_q;
  assign capture_rst = caprst_q;
  assign cmd_ok      = ok_q;
  assign cmd_err     = err_q;
  assign err_count   = err_count_q;
  assign state_debug = {1'b0, state_q};

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Bench for uart_cmd_receiver: a UART RX buffer model feeds bytes, frames are
// built from (opcode, payload, checksum corruption), and the expected outcome of
// each frame is queued for a monitor that compares it against the DUT strobes.
module tb_uart_cmd_receiver;

  localparam int unsigned Timeout = 20;
  localparam logic [7:0]  Sync    = 8'hA5;

  logic        clk;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        uld_rx_data;
  logic [2:0]  trig_mask;
  logic [15:0] sample_div;
  logic        arm_pulse;
  logic        capture_rst;
  logic        cmd_ok;
  logic        cmd_err;
  logic [7:0]  err_count;
  logic [2:0]  state_debug;

  uart_cmd_receiver #(
    .SYNC_BYTE      (Sync),
    .TIMEOUT_CYCLES (Timeout),
    .MASK_RESET     (3'b111),
    .DIV_RESET      (16'd1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .uld_rx_data (uld_rx_data),
    .trig_mask   (trig_mask),
    .sample_div  (sample_div),
    .arm_pulse   (arm_pulse),
    .capture_rst (capture_rst),
    .cmd_ok      (cmd_ok),
    .cmd_err     (cmd_err),
    .err_count   (err_count),
    .state_debug (state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic        arm;
    logic        crst;
    logic [2:0]  mask;
    logic [15:0] div;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] rx_q[$];
  int         checks   = 0;
  int         failures = 0;

  // Configuration the model believes is applied (used when queuing events).
  logic [2:0]  m_mask = 3'b111;
  logic [15:0] m_div  = 16'd1;

  int cyc      = 0;
  int last_cap = -1;
  int last_err = -1;
  int uld_cnt  = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the UART RX buffer model; serves the unload strobe.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (uld_rx_data) begin
      uld_cnt++;
      check_eq("uld_with_byte_waiting", (rx_q.size() > 0), 1);
      if (rx_q.size() > 0) rx_data = rx_q.pop_front();
      rx_empty = (rx_q.size() == 0);
    end
    if (state_debug == 3'd2) last_cap = cyc;
    if (cmd_err) last_err = cyc;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (rx_q.size() != 0 && n < 6000) begin
      tick();
      n++;
    end
    check_eq("rx_buffer_drained", (rx_q.size() == 0), 1);
  endtask

  task automatic drain();
    wait_empty();
    repeat (4) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit burst, input int idle);
    rx_q.push_back(b);
    rx_empty = 1'b0;
    if (!burst) begin
      wait_empty();
      repeat (idle) tick();
    end
  endtask

  task automatic push_ev(input bit ok, input bit arm, input bit crst);
    ev_t e;
    e.ok   = ok;
    e.arm  = arm;
    e.crst = crst;
    e.mask = m_mask;
    e.div  = m_div;
    exp_q.push_back(e);
  endtask

  // Sends one frame; 'corrupt' is XORed into the correct checksum.
  task automatic send_frame(input logic [7:0] opc, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] corrupt, input bit burst, input int idle,
                            input bit hold);
    int len;
    logic [7:0] chk;
    bit ok;
    len = (opc == 8'h01) ? 1 : (opc == 8'h02) ? 2 : (opc == 8'h03 || opc == 8'h04) ? 0 : -1;
    if (len < 0) begin
      push_ev(1'b0, 1'b0, 1'b0);
      send_byte(Sync, burst, idle);
      send_byte(opc, burst, idle);
    end else begin
      chk = opc ^ ((len >= 1) ? p0 : 8'h00) ^ ((len == 2) ? p1 : 8'h00) ^ corrupt;
      ok  = (corrupt == 8'h00) && !(opc == 8'h02 && {p0, p1} == 16'h0000);
      if (ok && opc == 8'h01) m_mask = p0[2:0];
      if (ok && opc == 8'h02) m_div = {p0, p1};
      push_ev(ok, ok && (opc == 8'h03), ok && (opc == 8'h04));
      send_byte(Sync, burst, idle);
      send_byte(opc, burst, idle);
      if (len >= 1) send_byte(p0, burst, idle);
      if (len == 2) send_byte(p1, burst, idle);
      send_byte(chk, burst, idle);
    end
    if (!hold) drain();
  endtask

  // Monitor: every DUT strobe cycle consumes one expected event.
  initial begin : monitor
    logic [2:0]  cur_mask;
    logic [15:0] cur_div;
    int          exp_err;
    int          mcyc;
    int          last_uld;
    ev_t         e;
    cur_mask = 3'b111;
    cur_div  = 16'd1;
    exp_err  = 0;
    mcyc     = 0;
    last_uld = -10;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_mask = 3'b111;
        cur_div  = 16'd1;
        exp_err  = 0;
        last_uld = -10;
      end else begin
        mcyc++;
        if (uld_rx_data) begin
          check_eq("uld_spacing_ge3", ((mcyc - last_uld) >= 3), 1);
          last_uld = mcyc;
        end
        if (cmd_ok || cmd_err || arm_pulse || capture_rst) begin
          check_eq("event_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("cmd_ok", cmd_ok, e.ok);
            check_eq("cmd_err", cmd_err, !e.ok);
            check_eq("arm_pulse", arm_pulse, e.arm);
            check_eq("capture_rst", capture_rst, e.crst);
            cur_mask = e.mask;
            cur_div  = e.div;
            if (!e.ok && exp_err < 255) exp_err++;
          end
        end
        check_eq("trig_mask", trig_mask, cur_mask);
        check_eq("sample_div", sample_div, cur_div);
        check_eq("err_count", err_count, exp_err);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    int          u0;
    logic [7:0]  opc, p0, p1, corrupt, j;
    int          sel;
    int          n;
    bit          burst;
    rst      = 1'b1;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_trig_mask", trig_mask, 3'b111);
    check_eq("rst_sample_div", sample_div, 16'd1);
    check_eq("rst_err_count", err_count, 8'd0);
    check_eq("rst_strobes", {uld_rx_data, arm_pulse, capture_rst, cmd_ok, cmd_err}, 5'd0);
    check_eq("rst_state", state_debug, 3'd0);

    // Directed frames.
    u0 = uld_cnt;
    send_frame(8'h01, 8'h05, 8'h00, 8'h00, 1'b0, 0, 1'b0);
    check_eq("uld_count_set_mask", uld_cnt - u0, 4);
    send_frame(8'h02, 8'h12, 8'h34, 8'h00, 1'b1, 0, 1'b0);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    send_frame(8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
    send_frame(8'h01, 8'h07, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    send_frame(8'h01, 8'h07, 8'h00, 8'h06, 1'b1, 0, 1'b0);
    send_frame(8'h7E, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    // Back-to-back: second frame's sync follows the first CHK with no gap.
    send_frame(8'h01, 8'h02, 8'h00, 8'h00, 1'b1, 0, 1'b1);
    send_frame(8'h02, 8'hA5, 8'hA5, 8'h00, 1'b1, 0, 1'b0);

    // Randomized frames, optional junk, mixed pacing.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          j = 8'($urandom_range(0, 255));
          if (j == Sync) j = 8'h00;
          send_byte(j, 1'b1, 0);
        end
      end
      sel = $urandom_range(0, 9);
      opc = (sel < 8) ? 8'((sel % 4) + 1) : 8'($urandom_range(5, 255));
      p0  = 8'($urandom_range(0, 255));
      p1  = 8'($urandom_range(0, 255));
      if (opc == 8'h02 && $urandom_range(0, 5) == 0) begin
        p0 = 8'h00;
        p1 = 8'h00;
      end
      corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      burst   = 1'($urandom_range(0, 1));
      send_frame(opc, p0, p1, corrupt, burst, $urandom_range(0, 4),
                 burst && ($urandom_range(0, 1) == 1));
    end
    drain();

    // Timeout after a partial frame.
    push_ev(1'b0, 1'b0, 1'b0);
    send_byte(Sync, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    last_err = -1;
    n = 0;
    while (last_err < 0 && n < 80) begin
      tick();
      n++;
    end
    check_eq("timeout_seen", (last_err >= 0), 1);
    check_eq("timeout_gap_window",
             ((last_err - last_cap) >= int'(Timeout) && (last_err - last_cap) <= int'(Timeout) + 1),
             1);
    check_eq("timeout_state_idle", state_debug, 3'd0);
    send_frame(8'h01, 8'h03, 8'h00, 8'h00, 1'b0, 0, 1'b0);

    // Reset between PAY0 and CHK of a SET_DIV frame.
    send_frame(8'h02, 8'h55, 8'h66, 8'h00, 1'b1, 0, 1'b0);
    send_byte(Sync, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h12, 1'b0, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_mask = 3'b111;
    m_div  = 16'd1;
    tick();
    check_eq("midrst_trig_mask", trig_mask, 3'b111);
    check_eq("midrst_sample_div", sample_div, 16'd1);
    check_eq("midrst_err_count", err_count, 8'd0);
    check_eq("midrst_strobes", {arm_pulse, capture_rst, cmd_ok, cmd_err}, 4'd0);
    send_byte(8'h26, 1'b0, 0);
    drain();
    send_frame(8'h02, 8'h00, 8'h10, 8'h00, 1'b0, 1, 1'b0);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) send_frame(8'h7E, 8'h00, 8'h00, 8'h00, 1'b1, 0, 1'b1);
    drain();
    check_eq("err_count_saturated", err_count, 8'hFF);
    check_eq("all_events_seen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
